// File: rtl/huffman_pkg.sv
// Shared sizing, state encoding and entry helpers for the Huffman bit decoder.
// Table entries are in marker form: the codeword sits right-aligned behind a leading '1'.
package huffman_pkg;

    localparam int SYM_W   = 2;
    localparam int MAX_LEN = 3;
    localparam int ENTRY_W = MAX_LEN + 1;
    localparam int NUM_SYM = 2 ** SYM_W;
    localparam int TABLE_W = NUM_SYM * ENTRY_W;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    // Entries with no marker bit above position 0 carry no codeword.
    localparam logic [ENTRY_W-1:0] ENTRY_UNUSED_0 = 4'b0000;
    localparam logic [ENTRY_W-1:0] ENTRY_UNUSED_1 = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2,
        ST_ERR   = 2'd3
    } dec_state_t;

    function automatic logic [ENTRY_W-1:0] to_marker(input logic [MAX_LEN-1:0] acc,
                                                     input logic [LEN_W-1:0]   len);
        return {1'b0, acc} | (ENTRY_W'(1) << len);
    endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Compares a marker-form accumulator against every table entry.
// When several entries match, the lowest index is reported.
module huffman_code_match
    import huffman_pkg::*;
(
    input  logic [TABLE_W-1:0] code_table,
    input  logic [ENTRY_W-1:0] marker,
    output logic               hit,
    output logic [SYM_W-1:0]   index
);

    logic [ENTRY_W-1:0] entry;

    // Scan downwards so the last assignment made is the lowest matching index.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        entry = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            entry = code_table[i*ENTRY_W +: ENTRY_W];
            if (entry != ENTRY_UNUSED_0 && entry != ENTRY_UNUSED_1 && entry == marker) begin
                hit   = 1'b1;
                index = SYM_W'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_bit_decoder.sv
// Serial Huffman decoder: shifts in code bits MSB-first, emits symbol indices
// over valid/ready, flags undecodable input and counts delivered symbols.
//
// state | meaning
// IDLE  | no table loaded since reset, bits refused
// SHIFT | accepting bits, accumulating the current codeword
// EMIT  | symbol held on SYM_OUT until the consumer takes it
// ERR   | no match within MAX_LEN bits, stuck until reset or table load
module huffman_bit_decoder
    import huffman_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [TABLE_W-1:0] CODE_TABLE,
    input  logic               TABLE_LOAD,
    input  logic               BIT_IN,
    input  logic               BIT_VALID,
    output logic               BIT_READY,
    output logic [SYM_W-1:0]   SYM_OUT,
    output logic               SYM_VALID,
    input  logic               SYM_READY,
    output logic               DEC_ERROR,
    output logic [CNT_W-1:0]   SYM_COUNT
);

    dec_state_t         state;
    logic [TABLE_W-1:0] table_q;
    logic [MAX_LEN-1:0] acc;
    logic [LEN_W-1:0]   len;

    logic [MAX_LEN-1:0] next_acc;
    logic [LEN_W-1:0]   next_len;
    logic [ENTRY_W-1:0] next_marker;
    logic               hit;
    logic [SYM_W-1:0]   hit_index;

    assign next_acc    = MAX_LEN'({acc, BIT_IN});
    assign next_len    = len + 1'b1;
    assign next_marker = to_marker(next_acc, next_len);

    huffman_code_match u_match (
        .code_table (table_q),
        .marker     (next_marker),
        .hit        (hit),
        .index      (hit_index)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            table_q   <= '0;
            acc       <= '0;
            len       <= '0;
            BIT_READY <= 1'b0;
            SYM_OUT   <= '0;
            SYM_VALID <= 1'b0;
            DEC_ERROR <= 1'b0;
            SYM_COUNT <= '0;
        end else if (TABLE_LOAD) begin
            // A load wins over any handshake in the same cycle; pending symbol is dropped.
            state     <= ST_SHIFT;
            table_q   <= CODE_TABLE;
            acc       <= '0;
            len       <= '0;
            BIT_READY <= 1'b1;
            SYM_VALID <= 1'b0;
            DEC_ERROR <= 1'b0;
            SYM_COUNT <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (BIT_VALID && BIT_READY) begin
                        acc <= next_acc;
                        len <= next_len;
                        if (hit) begin
                            SYM_OUT   <= hit_index;
                            SYM_VALID <= 1'b1;
                            BIT_READY <= 1'b0;
                            state     <= ST_EMIT;
                        end else if (next_len == LEN_W'(MAX_LEN)) begin
                            DEC_ERROR <= 1'b1;
                            BIT_READY <= 1'b0;
                            state     <= ST_ERR;
                        end
                    end
                end
                ST_EMIT: begin
                    if (SYM_READY) begin
                        SYM_VALID <= 1'b0;
                        SYM_COUNT <= SYM_COUNT + 1'b1;
                        acc       <= '0;
                        len       <= '0;
                        BIT_READY <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_bit_decoder.sv
// Directed bench for huffman_bit_decoder: a table of single-codeword vectors
// plus hand-written sequences for backpressure, reset, error recovery and wrap.
module tb_huffman_bit_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] code_table;
    logic        table_load;
    logic        bit_in;
    logic        bit_valid;
    logic        sym_ready;

    logic        bit_ready;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic        dec_error;
    logic [15:0] sym_count;

    // Narrow-counter copy on the same stimulus, used to reach the wrap point quickly.
    logic        bit_ready_n;
    logic [1:0]  sym_out_n;
    logic        sym_valid_n;
    logic        dec_error_n;
    logic [3:0]  sym_count_n;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    huffman_bit_decoder u_dut (
        .CLK        (clk),
        .RST        (rst),
        .CODE_TABLE (code_table),
        .TABLE_LOAD (table_load),
        .BIT_IN     (bit_in),
        .BIT_VALID  (bit_valid),
        .BIT_READY  (bit_ready),
        .SYM_OUT    (sym_out),
        .SYM_VALID  (sym_valid),
        .SYM_READY  (sym_ready),
        .DEC_ERROR  (dec_error),
        .SYM_COUNT  (sym_count)
    );

    huffman_bit_decoder #(.CNT_W(4)) u_dut_narrow (
        .CLK        (clk),
        .RST        (rst),
        .CODE_TABLE (code_table),
        .TABLE_LOAD (table_load),
        .BIT_IN     (bit_in),
        .BIT_VALID  (bit_valid),
        .BIT_READY  (bit_ready_n),
        .SYM_OUT    (sym_out_n),
        .SYM_VALID  (sym_valid_n),
        .SYM_READY  (sym_ready),
        .DEC_ERROR  (dec_error_n),
        .SYM_COUNT  (sym_count_n)
    );

    typedef struct {
        string       name;
        logic [15:0] tbl;
        int          nbits;
        logic [2:0]  bits;
        logic        exp_err;
        logic [1:0]  exp_sym;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_table(input logic [15:0] t);
        code_table = t;
        table_load = 1'b1;
        @(negedge clk);
        table_load = 1'b0;
    endtask

    // Presents one bit and returns at the negedge after it was accepted.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bit_ready) begin
            check("bit_accept_timeout", 32'(bit_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"fe62_sym0",   16'hFE62, 1, 3'b000, 1'b0, 2'd0};
        vecs[1]  = '{"fe62_sym1",   16'hFE62, 2, 3'b010, 1'b0, 2'd1};
        vecs[2]  = '{"fe62_sym2",   16'hFE62, 3, 3'b110, 1'b0, 2'd2};
        vecs[3]  = '{"fe62_sym3",   16'hFE62, 3, 3'b111, 1'b0, 2'd3};
        vecs[4]  = '{"0062_err111", 16'h0062, 3, 3'b111, 1'b1, 2'd0};
        vecs[5]  = '{"0062_err110", 16'h0062, 3, 3'b110, 1'b1, 2'd0};
        vecs[6]  = '{"5ad3_01",     16'h5AD3, 2, 3'b001, 1'b0, 2'd3};
        vecs[7]  = '{"5ad3_1",      16'h5AD3, 1, 3'b001, 1'b0, 2'd0};
        vecs[8]  = '{"5ad3_err000", 16'h5AD3, 3, 3'b000, 1'b1, 2'd0};
        vecs[9]  = '{"6620_dup10",  16'h6620, 2, 3'b010, 1'b0, 2'd2};
        vecs[10] = '{"1111_unused", 16'h1111, 3, 3'b000, 1'b1, 2'd0};

        rst        = 1'b1;
        code_table = 16'h0;
        table_load = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sym_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_sym_out",   32'(sym_out),   32'd0);
        check("rst_dec_error", 32'(dec_error), 32'd0);
        check("rst_sym_count", 32'(sym_count), 32'd0);

        // Before any table load, bits are refused.
        bit_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_bit_ready", 32'(bit_ready), 32'd0);
        end
        bit_valid = 1'b0;

        for (int v = 0; v < 11; v++) begin
            load_table(vecs[v].tbl);
            for (int k = 0; k < vecs[v].nbits; k++)
                send_bit(vecs[v].bits[vecs[v].nbits-1-k]);
            if (vecs[v].exp_err) begin
                check({vecs[v].name, "_err"},       32'(dec_error), 32'd1);
                check({vecs[v].name, "_bit_ready"}, 32'(bit_ready), 32'd0);
                check({vecs[v].name, "_valid"},     32'(sym_valid), 32'd0);
            end else begin
                check({vecs[v].name, "_valid"}, 32'(sym_valid), 32'd1);
                check({vecs[v].name, "_sym"},   32'(sym_out),   32'(vecs[v].exp_sym));
                check({vecs[v].name, "_err"},   32'(dec_error), 32'd0);
            end
            @(negedge clk);
            check({vecs[v].name, "_count"}, 32'(sym_count), vecs[v].exp_err ? 32'd0 : 32'd1);
        end

        // Continuous stream 0,10,110,111 with one bubble per symbol.
        load_table(16'hFE62);
        send_bit(1'b0);
        check("s1_valid0", 32'(sym_valid), 32'd1);
        check("s1_sym0",   32'(sym_out),   32'd0);
        send_bit(1'b1); send_bit(1'b0);
        check("s1_valid1", 32'(sym_valid), 32'd1);
        check("s1_sym1",   32'(sym_out),   32'd1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("s1_valid2", 32'(sym_valid), 32'd1);
        check("s1_sym2",   32'(sym_out),   32'd2);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("s1_valid3", 32'(sym_valid), 32'd1);
        check("s1_sym3",   32'(sym_out),   32'd3);
        @(negedge clk);
        check("s1_count",  32'(sym_count), 32'd4);
        check("s1_error",  32'(dec_error), 32'd0);

        // Error is sticky until a new table load.
        load_table(16'h0062);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("s2_err", 32'(dec_error), 32'd1);
        bit_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("s2_hold_ready", 32'(bit_ready), 32'd0);
            check("s2_hold_err",   32'(dec_error), 32'd1);
        end
        bit_valid = 1'b0;
        load_table(16'hFE62);
        check("s2_err_cleared", 32'(dec_error), 32'd0);
        send_bit(1'b1); send_bit(1'b0);
        check("s2_resume_sym", 32'(sym_out), 32'd1);
        @(negedge clk);

        // Backpressure: symbol held while the consumer stalls.
        sym_ready = 1'b0;
        load_table(16'hFE62);
        send_bit(1'b1); send_bit(1'b0);
        repeat (5) begin
            check("s4_valid",     32'(sym_valid), 32'd1);
            check("s4_sym",       32'(sym_out),   32'd1);
            check("s4_bit_ready", 32'(bit_ready), 32'd0);
            check("s4_count",     32'(sym_count), 32'd0);
            @(negedge clk);
        end
        sym_ready = 1'b1;
        @(negedge clk);
        check("s4_release_count", 32'(sym_count), 32'd1);
        check("s4_release_valid", 32'(sym_valid), 32'd0);
        @(negedge clk);
        check("s4_single_incr",   32'(sym_count), 32'd1);

        // Reset in the middle of a codeword wipes the table too.
        load_table(16'hFE62);
        send_bit(1'b0);
        @(negedge clk);
        send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_bit_ready", 32'(bit_ready), 32'd0);
        check("s5_sym_valid", 32'(sym_valid), 32'd0);
        check("s5_sym_out",   32'(sym_out),   32'd0);
        check("s5_dec_error", 32'(dec_error), 32'd0);
        check("s5_sym_count", 32'(sym_count), 32'd0);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("s5_ignored", 32'(bit_ready), 32'd0);
            check("s5_no_sym",  32'(sym_valid), 32'd0);
        end
        bit_valid = 1'b0;
        load_table(16'hFE62);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("s5_resume_sym", 32'(sym_out), 32'd2);
        @(negedge clk);

        // Counter wrap on the narrow copy, then a load coincident with a bit.
        load_table(16'hFE62);
        repeat (15) begin
            send_bit(1'b0);
            @(negedge clk);
        end
        check("s6_narrow_full", 32'(sym_count_n), 32'hF);
        send_bit(1'b0);
        @(negedge clk);
        check("s6_narrow_wrap", 32'(sym_count_n), 32'd0);
        check("s6_wide_count",  32'(sym_count),   32'd16);

        code_table = 16'hFE62;
        bit_in     = 1'b1;
        bit_valid  = 1'b1;
        table_load = 1'b1;
        @(negedge clk);
        table_load = 1'b0;
        bit_valid  = 1'b0;
        check("s6_load_count",   32'(sym_count),   32'd0);
        check("s6_load_count_n", 32'(sym_count_n), 32'd0);
        check("s6_load_valid",   32'(sym_valid),   32'd0);
        check("s6_load_ready",   32'(bit_ready),   32'd1);
        send_bit(1'b0);
        check("s6_bit_not_consumed", 32'(sym_out),   32'd0);
        check("s6_valid_after",      32'(sym_valid), 32'd1);
        check("s6_narrow_sym",       32'(sym_out_n), 32'd0);
        check("s6_narrow_ready",     32'(bit_ready_n), 32'd0);
        check("s6_narrow_valid",     32'(sym_valid_n), 32'd1);
        check("s6_narrow_err",       32'(dec_error_n), 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
